// File: rtl/serial_cmp_pkg.sv
// Shared definitions for the bit-serial comparators: state encoding.
// Words are streamed LSB first, so the running bit index equals the bit position.
package serial_cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CMP  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/serial_word_eq.sv
// Bit-serial word comparator: accumulates per-bit equality over an N-bit word
// and reports word-equal, mismatch count and first mismatching bit index.
module serial_word_eq
    import serial_cmp_pkg::*;
#(
    parameter int N  = 8,
    parameter int IW = 3,
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          bit_valid,
    input  logic          a_bit,
    input  logic          b_bit,
    output logic          ready,
    output logic          done_tick,
    output logic          eq,
    output logic [CW-1:0] mism_cnt,
    output logic [IW-1:0] first_idx
);

    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    state_t        state_reg, state_next;
    logic [IW-1:0] idx_reg, idx_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [IW-1:0] first_reg, first_next;
    logic          eq_reg, eq_next;
    logic          bit_eq;

    assign bit_eq = ~(a_bit ^ b_bit);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
            cnt_reg   <= '0;
            first_reg <= '0;
            eq_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            cnt_reg   <= cnt_next;
            first_reg <= first_next;
            eq_reg    <= eq_next;
        end
    end

    // Next-state and datapath: results stay untouched outside CMP so they hold until the next start.
    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        cnt_next   = cnt_reg;
        first_next = first_reg;
        eq_next    = eq_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = CMP;
                    idx_next   = '0;
                    cnt_next   = '0;
                    first_next = '0;
                    eq_next    = 1'b1;
                end
            end
            CMP: begin
                if (bit_valid) begin
                    if (!bit_eq) begin
                        cnt_next = cnt_reg + CW'(1);
                        if (eq_reg) begin
                            first_next = idx_reg;
                            eq_next    = 1'b0;
                        end
                    end
                    idx_next = idx_reg + IW'(1);
                    if (idx_reg == LAST_IDX) begin
                        state_next = DONE;
                    end
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs are decoded from state or driven straight from registers.
    always_comb begin
        ready     = (state_reg == IDLE);
        done_tick = (state_reg == DONE);
    end

    assign eq        = eq_reg;
    assign mism_cnt  = cnt_reg;
    assign first_idx = first_reg;

endmodule
